// File: rtl/iir_test_pkg.sv
// Shared defaults and checker state codes for the IIR hardware self-test blocks.
package iir_test_pkg;

  localparam int DW_DEF   = 16;
  localparam int AW_DEF   = 11;
  localparam int N_DEF    = 2048;
  localparam int SKIP_DEF = 1;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_WAIT_STABLE = 3'd1;
  localparam logic [2:0] ST_SKIP        = 3'd2;
  localparam logic [2:0] ST_CAPTURE     = 3'd3;
  localparam logic [2:0] ST_FLUSH       = 3'd4;
  localparam logic [2:0] ST_DONE        = 3'd5;

  function automatic logic is_run_state(input logic [2:0] st);
    return st inside {ST_WAIT_STABLE, ST_SKIP, ST_CAPTURE, ST_FLUSH};
  endfunction

endpackage

// File: rtl/iir_out_checker_if.sv
// Sample stream, reference load and capture readback signals of the output checker.
interface iir_out_checker_if
  import iir_test_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
);

  logic [DW-1:0] din;
  logic          din_valid;
  logic          stable_in;
  logic          ref_we;
  logic [AW-1:0] ref_waddr;
  logic [DW-1:0] ref_wdata;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  modport master (
    output din, din_valid, stable_in, ref_we, ref_waddr, ref_wdata, rd_addr,
    input  rd_data
  );

  modport slave (
    input  din, din_valid, stable_in, ref_we, ref_waddr, ref_wdata, rd_addr,
    output rd_data
  );

endinterface

// File: rtl/iir_sdp_ram.sv
// Simple dual-port RAM, one write port and one synchronous read port.
// A same-address read during a write returns the previous contents.
module iir_sdp_ram
  import iir_test_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the output register is reset; array contents survive rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/iir_out_checker.sv
// Captures N settled filter samples, compares them with a preloaded golden
// reference and reports error count, max |diff| and first mismatch index.
module iir_out_checker
  import iir_test_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF,
  parameter int N    = N_DEF,
  parameter int SKIP = SKIP_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arm,
  iir_out_checker_if.slave     bus,
  output logic                 busy,
  output logic                 done,
  output logic [AW:0]          out_cnt,
  output logic [AW:0]          err_cnt,
  output logic [DW:0]          max_diff,
  output logic [AW-1:0]        first_err
);

  localparam int SW = (SKIP > 1) ? $clog2(SKIP) : 1;
  localparam logic [AW:0]   LAST_IDX  = (AW+1)'(N - 1);
  localparam logic [SW-1:0] SKIP_LAST = SW'((SKIP > 0) ? SKIP - 1 : 0);

  logic [2:0]    state;
  logic [SW-1:0] skip_cnt;
  logic          accept;
  logic          ref_wr;

  logic          s1_valid;
  logic [DW-1:0] s1_din;
  logic [AW-1:0] s1_idx;
  logic [DW-1:0] ref_q;
  logic [DW:0]   diff;
  logic [DW:0]   abs_diff;

  logic          s2_valid;
  logic [DW:0]   s2_abs;
  logic [AW-1:0] s2_idx;

  logic [DW-1:0] rd_q;

  assign busy   = is_run_state(state);
  assign done   = (state == ST_DONE);
  assign accept = !arm && (state == ST_CAPTURE) && bus.din_valid;
  assign ref_wr = bus.ref_we && !busy;

  assign bus.rd_data = rd_q;

  iir_sdp_ram #(.DW(DW), .AW(AW)) u_capture (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (accept),
    .waddr (out_cnt[AW-1:0]),
    .wdata (bus.din),
    .raddr (bus.rd_addr),
    .rdata (rd_q)
  );

  iir_sdp_ram #(.DW(DW), .AW(AW)) u_reference (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ref_wr),
    .waddr (bus.ref_waddr),
    .wdata (bus.ref_wdata),
    .raddr (out_cnt[AW-1:0]),
    .rdata (ref_q)
  );

  // The valid seen in the same cycle as the first stable_in is always dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
    end else if (arm) begin
      state    <= ST_WAIT_STABLE;
      skip_cnt <= '0;
    end else begin
      case (state)
        ST_WAIT_STABLE: begin
          if (bus.stable_in) begin
            state <= (SKIP == 0) ? ST_CAPTURE : ST_SKIP;
          end
        end
        ST_SKIP: begin
          if (bus.din_valid) begin
            if (skip_cnt == SKIP_LAST) begin
              state <= ST_CAPTURE;
            end
            skip_cnt <= skip_cnt + 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (accept && (out_cnt == LAST_IDX)) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (!s1_valid && !s2_valid) begin
            state <= ST_DONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt  <= '0;
      s1_valid <= 1'b0;
      s1_din   <= '0;
      s1_idx   <= '0;
    end else if (arm) begin
      out_cnt  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        out_cnt <= out_cnt + 1'b1;
        s1_din  <= bus.din;
        s1_idx  <= out_cnt[AW-1:0];
      end
    end
  end

  // DW+1 bits hold any difference of two DW-bit signed values without overflow.
  always_comb begin
    diff     = {s1_din[DW-1], s1_din} - {ref_q[DW-1], ref_q};
    abs_diff = diff[DW] ? (~diff + 1'b1) : diff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_abs   <= '0;
      s2_idx   <= '0;
    end else if (arm) begin
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_abs <= abs_diff;
        s2_idx <= s1_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt   <= '0;
      max_diff  <= '0;
      first_err <= '0;
    end else if (arm) begin
      err_cnt   <= '0;
      max_diff  <= '0;
      first_err <= '0;
    end else if (s2_valid && (s2_abs != '0)) begin
      err_cnt <= err_cnt + 1'b1;
      if (err_cnt == '0) begin
        first_err <= s2_idx;
      end
      if (s2_abs > max_diff) begin
        max_diff <= s2_abs;
      end
    end
  end

endmodule
